serial_add_sub: RTL
===================

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, width 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, width 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, width 1, an operation request that is sampled only in IDLE.
REQ-005 The block SHALL have port sub, input, width 1, the operation select: 0 gives a+b, 1 gives a-b (two's complement); it is sampled together with start.
REQ-006 The block SHALL have ports a and b, inputs, width WIDTH, the operands, captured on the accepting edge.
REQ-007 The block SHALL have port busy, output, width 1, asserted while in SHIFT.
REQ-008 The block SHALL have port done, output, width 1, a one-cycle completion pulse.
REQ-009 The block SHALL have port result, output, width WIDTH, the sum or difference, held until the next completion.
REQ-010 The block SHALL have port cout, output, width 1, the final carry out; for sub=1, cout=0 means a borrow occurred (unsigned a<b).
REQ-011 The block SHALL have port overflow, output, width 1, the signed overflow, equal to the carry into the MSB XOR the carry out of the MSB.

Function
REQ-012 The datapath SHALL be one full-adder cell, reused one bit per cycle, LSB first; no parallel WIDTH-bit adder is permitted.
REQ-013 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-014 In IDLE with start=1 at edge k, the block SHALL load the a shift register with a, load the b shift register with b XOR {WIDTH{sub}}, preset the carry to sub, clear the bit counter, and go to SHIFT.
REQ-015 In SHIFT, each edge SHALL add the LSBs of both shift registers plus the carry, shift the sum bit into the result register from the MSB side, store the new carry, and increment the counter.
REQ-016 At edge k+WIDTH (the counter reaches WIDTH-1 before that edge), the block SHALL register cout and overflow, update result, and go to DONE.
REQ-017 done SHALL be 1 only during DONE, exactly one cycle; DONE SHALL go to IDLE unconditionally on the next edge.
REQ-018 Latency SHALL be fixed: done is high in the cycle that follows edge k+WIDTH, regardless of the operand values.
REQ-019 The block SHALL ignore start in SHIFT and DONE; such a start is neither queued nor does it disturb the in-flight operation.
REQ-020 The block SHALL accept start in the cycle after done (back-to-back throughput of one operation per WIDTH+2 cycles).
REQ-021 Changes on a, b or sub after acceptance SHALL NOT affect the in-flight operation.
REQ-022 result, cout and overflow SHALL change only at the completion edge; the partial result SHALL be held internally and SHALL NOT be visible mid-operation.
REQ-023 Width rule: all arithmetic SHALL be modulo 2^WIDTH; cout SHALL be bit WIDTH of a + (b XOR sub-mask) + sub.

Reset
REQ-024 Reset SHALL be asserted asynchronously and released synchronously to clk at the block boundary (the integrator's responsibility); while rst_n=0 the block SHALL hold state=IDLE, busy=0, done=0, result=0, cout=0, overflow=0, and all shift registers, carry and counter at 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation immediately; no done pulse SHALL follow, and result SHALL read 0.
REQ-026 After rst_n rises, a start in the first IDLE cycle SHALL be accepted.

Verification
REQ-027 The bench SHALL cover add (WIDTH=4): a=5, b=3, sub=0 -> done 5 cycles after the start edge, result=8, cout=0, overflow=1.
REQ-028 The bench SHALL cover subtract with borrow: a=3, b=5, sub=1 -> result=14 (0xE), cout=0, overflow=0.
REQ-029 The bench SHALL cover the wrap and signed edge cases: a=15, b=1, sub=0 -> result=0, cout=1, overflow=0; and a=8, b=1, sub=1 -> result=7, cout=1, overflow=1.
REQ-030 The bench SHALL cover busy-ignore: start pulsed with a=1, b=1 two cycles into an operation a=6, b=2, sub=1 -> exactly one done, result=4; busy=1 for exactly 4 cycles.
REQ-031 The bench SHALL cover reset mid-op: rst_n=0 at cycle 2 of a=7, b=7 -> all outputs are 0 immediately, no done, and a new start after release completes normally.
REQ-032 The bench SHALL cover back-to-back operation and exhaustive checking: start asserted the cycle after each done over all 4-bit a, b and sub combinations -> every result, cout and overflow matches a reference model.

Source files
------------

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell reused LSB first over WIDTH cycles.
// The partial sum stays internal; result, cout and overflow update only on the completion edge.
module serial_add_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic sum_bit;
    logic carry_out;
    logic last_bit;

    // The single full-adder cell
    assign sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
    assign carry_out = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign last_bit  = (cnt == CW'(WIDTH - 1));

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction as a + ~b + 1: invert b and preset the carry
                        a_sr  <= a;
                        b_sr  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    acc   <= {sum_bit, acc[WIDTH-1:1]};
                    carry <= carry_out;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        // carry still holds the carry into the MSB here
                        result   <= {sum_bit, acc[WIDTH-1:1]};
                        cout     <= carry_out;
                        overflow <= carry ^ carry_out;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
